// File: rtl/sramb_pkg.sv
// sramb_pkg: shared types and width helpers for the asymmetric true-dual-port RAM.
//   sramb_state_t      - clear sequencer state (CLEAR, READY)
//   WF_READ_OLD/NEW    - read-during-write mode values for WRITE_FIRST
//   sramb_lanes()      - lanes per wide word, 2**ratio_log2
//   sramb_data_width_b - wide port data width
//   sramb_addr_width_b - wide port address width
package sramb_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } sramb_state_t;

  localparam int unsigned WF_READ_OLD = 0;
  localparam int unsigned WF_READ_NEW = 1;

  function automatic int unsigned sramb_lanes(input int unsigned ratio_log2);
    return 32'd1 << ratio_log2;
  endfunction

  function automatic int unsigned sramb_data_width_b(input int unsigned data_width_a,
                                                     input int unsigned ratio_log2);
    return data_width_a << ratio_log2;
  endfunction

  function automatic int unsigned sramb_addr_width_b(input int unsigned addr_width_a,
                                                     input int unsigned ratio_log2);
    return addr_width_a - ratio_log2;
  endfunction

endpackage

// File: rtl/sramb_asym_tdp_clear_seq.sv
// sramb_clear_seq: post-reset memory clear sequencer and wide-port write mux.
//   clk, rst            - clock, async active-high reset
//   en_b, we_b          - wide port enable and per-lane write mask
//   addr_b, din_b       - wide port address and write data
//   busy                - high while the array is being cleared
//   wr_addr/wr_data     - wide write address/data into the array
//   wr_mask             - per-lane wide write strobes into the array
// While clearing, the counter owns the wide write path and writes zero words;
// afterwards the user's port B write is passed through (gated by en_b).
module sramb_clear_seq
  import sramb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTHB = 10,
  parameter int unsigned DATA_WIDTHB = 16,
  parameter int unsigned LANES       = 16,
  parameter int unsigned INIT_CLEAR  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_b,
  input  logic [LANES-1:0]       we_b,
  input  logic [ADDR_WIDTHB-1:0] addr_b,
  input  logic [DATA_WIDTHB-1:0] din_b,
  output logic                   busy,
  output logic [ADDR_WIDTHB-1:0] wr_addr,
  output logic [DATA_WIDTHB-1:0] wr_data,
  output logic [LANES-1:0]       wr_mask
);

  sramb_state_t           state;
  logic [ADDR_WIDTHB-1:0] ctr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? CLEAR : READY;
      ctr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ctr <= ctr + 1'b1;
          if (ctr == '1) state <= READY;
        end
        READY:   state <= READY;
        default: state <= READY;
      endcase
    end
  end

  assign busy = (state == CLEAR);

  always_comb begin
    wr_addr = addr_b;
    wr_data = din_b;
    wr_mask = en_b ? we_b : '0;
    if (busy) begin
      wr_addr = ctr;
      wr_data = '0;
      wr_mask = '1;
    end
  end

endmodule

// File: rtl/sramb_asym_tdp.sv
// sramb_asym_tdp: single-clock true-dual-port RAM, narrow port A / wide port B.
//   clk, rst                 - clock, async active-high reset
//   en_a, we_a, addr_a, din_a - narrow port access (one lane per address)
//   dout_a, vld_a            - narrow read data and valid strobe
//   en_b, we_b, addr_b, din_b - wide port access with per-lane write mask
//   dout_b, vld_b            - wide read data and valid strobe
//   busy                     - post-reset clear in progress
//   collision                - pulse when A and B write the same lane together
// Optional macro SRAMB_ASYM_OREG_EN adds one output register stage on both
// ports (read data, valid and collision all one cycle later).
module sramb_asym_tdp
  import sramb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTHA = 1,
  parameter  int unsigned ADDR_WIDTHA = 14,
  parameter  int unsigned RATIO_LOG2  = 4,
  parameter  int unsigned WRITE_FIRST = 0,
  parameter  int unsigned INIT_CLEAR  = 1,
  localparam int unsigned LANES       = sramb_lanes(RATIO_LOG2),
  localparam int unsigned DATA_WIDTHB = sramb_data_width_b(DATA_WIDTHA, RATIO_LOG2),
  localparam int unsigned ADDR_WIDTHB = sramb_addr_width_b(ADDR_WIDTHA, RATIO_LOG2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_a,
  input  logic                   we_a,
  input  logic [ADDR_WIDTHA-1:0] addr_a,
  input  logic [DATA_WIDTHA-1:0] din_a,
  output logic [DATA_WIDTHA-1:0] dout_a,
  output logic                   vld_a,
  input  logic                   en_b,
  input  logic [LANES-1:0]       we_b,
  input  logic [ADDR_WIDTHB-1:0] addr_b,
  input  logic [DATA_WIDTHB-1:0] din_b,
  output logic [DATA_WIDTHB-1:0] dout_b,
  output logic                   vld_b,
  output logic                   busy,
  output logic                   collision
);

  localparam int unsigned DEPTHB = 1 << ADDR_WIDTHB;

  logic [DATA_WIDTHB-1:0] mem [DEPTHB];

  logic [ADDR_WIDTHB-1:0] a_word;
  logic [RATIO_LOG2-1:0]  a_lane;
  logic [ADDR_WIDTHB-1:0] wr_addr;
  logic [DATA_WIDTHB-1:0] wr_data;
  logic [LANES-1:0]       wr_mask;
  logic                   collide;
  logic                   a_we;
  logic                   rd_a_en;
  logic                   rd_b_en;
  logic [DATA_WIDTHB-1:0] a_old_word;
  logic [DATA_WIDTHA-1:0] a_rd;
  logic [DATA_WIDTHB-1:0] b_rd;

  logic [DATA_WIDTHA-1:0] dout_a1;
  logic [DATA_WIDTHB-1:0] dout_b1;
  logic                   vld_a1;
  logic                   vld_b1;
  logic                   col1;

  assign a_word = addr_a[ADDR_WIDTHA-1:RATIO_LOG2];
  assign a_lane = addr_a[RATIO_LOG2-1:0];

  sramb_clear_seq #(
    .ADDR_WIDTHB (ADDR_WIDTHB),
    .DATA_WIDTHB (DATA_WIDTHB),
    .LANES       (LANES),
    .INIT_CLEAR  (INIT_CLEAR)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .en_b    (en_b),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .din_b   (din_b),
    .busy    (busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mask (wr_mask)
  );

  // Port B wins a same-lane write; the A write is simply not performed.
  assign collide = en_a & we_a & en_b & we_b[a_lane] & (a_word == addr_b) & ~busy;
  assign a_we    = en_a & we_a & ~busy & ~collide;
  assign rd_a_en = en_a & ~busy;
  assign rd_b_en = en_b & ~busy;

  // Array: no reset; cleared by the sequencer through the wide write path.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_mask[i]) mem[wr_addr][i*DATA_WIDTHA +: DATA_WIDTHA] <= wr_data[i*DATA_WIDTHA +: DATA_WIDTHA];
    end
    if (a_we) mem[a_word][a_lane*DATA_WIDTHA +: DATA_WIDTHA] <= din_a;
  end

  // Read data uses the pre-edge array contents, so a cross-port same-cycle
  // write is never visible; own-port bypass only in write-first mode.
  always_comb begin
    a_old_word = mem[a_word];
    a_rd       = a_old_word[a_lane*DATA_WIDTHA +: DATA_WIDTHA];
    if (WRITE_FIRST == WF_READ_NEW && we_a) a_rd = din_a;
    b_rd = mem[addr_b];
    if (WRITE_FIRST == WF_READ_NEW) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (we_b[i]) b_rd[i*DATA_WIDTHA +: DATA_WIDTHA] = din_b[i*DATA_WIDTHA +: DATA_WIDTHA];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a1 <= '0;
      dout_b1 <= '0;
      vld_a1  <= 1'b0;
      vld_b1  <= 1'b0;
      col1    <= 1'b0;
    end else begin
      vld_a1 <= rd_a_en;
      vld_b1 <= rd_b_en;
      col1   <= collide;
      if (rd_a_en) dout_a1 <= a_rd;
      if (rd_b_en) dout_b1 <= b_rd;
    end
  end

`ifdef SRAMB_ASYM_OREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a    <= '0;
      dout_b    <= '0;
      vld_a     <= 1'b0;
      vld_b     <= 1'b0;
      collision <= 1'b0;
    end else begin
      dout_a    <= dout_a1;
      dout_b    <= dout_b1;
      vld_a     <= vld_a1;
      vld_b     <= vld_b1;
      collision <= col1;
    end
  end
`else
  assign dout_a    = dout_a1;
  assign dout_b    = dout_b1;
  assign vld_a     = vld_a1;
  assign vld_b     = vld_b1;
  assign collision = col1;
`endif

endmodule

// File: tb/tb_sramb_asym_tdp.sv
// tb_sramb_asym_tdp: directed bench for sramb_asym_tdp with default widths.
// Two instances share all inputs: dut reads old data on own-port writes,
// dut_wf returns new data, so both read-during-write modes are compared.
module tb_sramb_asym_tdp;

`ifdef SRAMB_ASYM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a, we_a;
  logic [13:0] addr_a;
  logic [0:0]  din_a;
  logic        en_b;
  logic [15:0] we_b;
  logic [9:0]  addr_b;
  logic [15:0] din_b;

  logic [0:0]  dout_a, dout_a_wf;
  logic [15:0] dout_b, dout_b_wf;
  logic        vld_a, vld_b, busy, collision;
  logic        vld_a_wf, vld_b_wf, busy_wf, collision_wf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sramb_asym_tdp #(.WRITE_FIRST(0)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .vld_a(vld_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b), .vld_b(vld_b),
    .busy(busy), .collision(collision)
  );

  sramb_asym_tdp #(.WRITE_FIRST(1)) dut_wf (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a_wf), .vld_a(vld_a_wf),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b_wf), .vld_b(vld_b_wf),
    .busy(busy_wf), .collision(collision_wf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = '0;   addr_b = '0; din_b = '0;
  endtask

  // Launch the currently driven access, then wait until its result is visible.
  task automatic go();
    tick();
    set_idle();
    repeat (LAT - 1) tick();
  endtask

  task automatic rd_a(input logic [13:0] a);
    en_a = 1'b1; addr_a = a;
    go();
  endtask

  task automatic rd_b(input logic [9:0] a);
    en_b = 1'b1; addr_b = a;
    go();
  endtask

  // Drive port writes for the whole clear window and count busy cycles.
  task automatic clear_window(input string tag);
    int   n;
    logic quiet;
    n = 0;
    quiet = 1'b0;
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0013; din_a = 1'b1;
    en_b = 1'b1; we_b = 16'hFFFF; addr_b = 10'h005; din_b = 16'hFFFF;
    while (busy && n < 5000) begin
      tick();
      n++;
      quiet = quiet | vld_a | vld_b | collision;
    end
    set_idle();
    chk({tag, "_busy_cycles"}, n, 1024);
    chk({tag, "_no_vld"}, quiet, 0);
  endtask

  logic [15:0] acc;
  logic        vok;
  logic [7:0]  exp_a3;

  initial begin
    set_idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_dout_a", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_vld", {vld_a, vld_b, collision}, 0);
    chk("rst_busy", busy, 1);
    tick();
    rst = 1'b0;

    clear_window("clr1");
    chk("clr1_dout_b", dout_b, 0);

    acc = '0;
    vok = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      rd_b(10'(i));
      acc = acc | dout_b;
      vok = vok & vld_b;
    end
    chk("clear_all_zero", acc, 0);
    chk("clear_all_vld", vok, 1);
    rd_a(14'h0013);
    chk("busy_a_write_dropped", dout_a, 0);

    // Two narrow writes land in lanes 3 and 0 of wide word 1.
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0013; din_a = 1'b1; go();
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0010; din_a = 1'b1; go();
    rd_b(10'h001);
    chk("a2b_dout_b", dout_b, 16'h0009);
    chk("a2b_vld_b", vld_b, 1);
    tick();
    chk("idle_vld_b", vld_b, 0);
    chk("idle_hold_dout_b", dout_b, 16'h0009);

    // Masked wide write, read back lane by lane.
    en_b = 1'b1; we_b = 16'h00F0; addr_b = 10'h002; din_b = 16'hFFFF; go();
    exp_a3 = 8'b1111_0000;
    for (int i = 0; i < 8; i++) begin
      rd_a(14'h0020 + 14'(i));
      chk($sformatf("b2a_lane%0d", i), dout_a, exp_a3[i]);
    end

    // Same-lane collision: B wins, pulse for one cycle.
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0035; din_a = 1'b0;
    en_b = 1'b1; we_b = 16'h0020; addr_b = 10'h003; din_b = 16'hFFFF;
    go();
    chk("col_pulse", collision, 1);
    chk("col_dout_a", dout_a, 0);
    chk("col_dout_a_wf", dout_a_wf, 0);
    chk("col_dout_b", dout_b, 16'h0000);
    chk("col_dout_b_wf", dout_b_wf, 16'h0020);
    tick();
    chk("col_pulse_end", collision, 0);
    rd_a(14'h0035);
    chk("col_b_wins", dout_a, 1);

    // Same word, different lanes: both stored, no collision.
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0031; din_a = 1'b1;
    en_b = 1'b1; we_b = 16'h0004; addr_b = 10'h003; din_b = 16'hFFFF;
    go();
    chk("nocol_pulse", collision, 0);
    rd_b(10'h003);
    chk("nocol_word", dout_b, 16'h0026);

    // Read-during-write modes on port B.
    en_b = 1'b1; we_b = 16'hFFFF; addr_b = 10'h005; din_b = 16'h1234; go();
    en_b = 1'b1; we_b = 16'hFFFF; addr_b = 10'h005; din_b = 16'hABCD; go();
    chk("rdw_old_b", dout_b, 16'h1234);
    chk("rdw_new_b", dout_b_wf, 16'hABCD);
    rd_b(10'h005);
    chk("rdw_after_b", dout_b, 16'hABCD);
    chk("rdw_after_b_wf", dout_b_wf, 16'hABCD);
    en_b = 1'b1; we_b = 16'h00FF; addr_b = 10'h005; din_b = 16'h0000; go();
    chk("rdw_mask_old", dout_b, 16'hABCD);
    chk("rdw_mask_new", dout_b_wf, 16'hAB00);

    // Read-during-write on port A.
    en_a = 1'b1; we_a = 1'b1; addr_a = 14'h0051; din_a = 1'b1; go();
    chk("rdw_old_a", dout_a, 0);
    chk("rdw_new_a", dout_a_wf, 1);

    // Cross-port: A reads a lane B writes in the same cycle -> old data.
    en_a = 1'b1; we_a = 1'b0; addr_a = 14'h0054;
    en_b = 1'b1; we_b = 16'h0010; addr_b = 10'h005; din_b = 16'hFFFF;
    go();
    chk("xport_a", dout_a, 0);
    chk("xport_a_wf", dout_a_wf, 0);
    chk("xport_b", dout_b, 16'hAB02);
    chk("xport_b_wf", dout_b_wf, 16'hAB12);

    // Reset mid-clear restarts the full clear.
    rst = 1'b1;
    #2;
    chk("rst2_dout_b", dout_b, 0);
    chk("rst2_busy", busy, 1);
    tick();
    rst = 1'b0;
    repeat (500) tick();
    chk("midclr_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_window("clr2");
    rd_b(10'h005);
    chk("clr2_word5", dout_b, 16'h0000);
    rd_b(10'h001);
    chk("clr2_word1", dout_b, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sramb_asym_tdp.md
Name: sramb_asym_tdp

Overview:
- Single-clock true-dual-port RAM with asymmetric port widths.
- Port A is narrow, one lane per address. Port B is wide, 2**RATIO_LOG2 lanes per address, with per-lane write mask.
- Adds a selectable read-during-write mode, a defined write-collision policy, read-valid strobes and a post-reset memory-clear sequencer.
- Sits between the CPU-side narrow bus and the wide video/sprite fetch path; successor to the fixed 1-bit/16-bit bitmap store.

Parameters:
- DATA_WIDTHA, 1, port A lane width in bits.
- ADDR_WIDTHA, 14, port A address width.
- RATIO_LOG2, 4, log2 of lanes per port B word. Derived: LANES=2**RATIO_LOG2, DATA_WIDTHB=DATA_WIDTHA*LANES, ADDR_WIDTHB=ADDR_WIDTHA-RATIO_LOG2.
- WRITE_FIRST, 0, read-during-write on the same port/location: 0 returns old data, 1 returns new data.
- INIT_CLEAR, 1, 1 zeroes the whole array after reset; 0 skips the clear.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write (qualified by en_a).
- addr_a  in  ADDR_WIDTHA  port A address.
- din_a  in  DATA_WIDTHA  port A write data.
- dout_a  out  DATA_WIDTHA  port A read data.
- vld_a  out  1  dout_a valid strobe.
- en_b  in  1  port B access enable.
- we_b  in  LANES  port B per-lane write mask (qualified by en_b).
- addr_b  in  ADDR_WIDTHB  port B address.
- din_b  in  DATA_WIDTHB  port B write data.
- dout_b  out  DATA_WIDTHB  port B read data.
- vld_b  out  1  dout_b valid strobe.
- busy  out  1  clear sequence in progress.
- collision  out  1  one-cycle pulse on a same-cycle A/B write to the same lane.

Behaviour:
- Lane mapping: A address {addr_b, i} is lane i of B word addr_b. Lane 0 occupies dout_b/din_b[DATA_WIDTHA-1:0].
- Reset, async: dout_a=0, dout_b=0, vld_a=0, vld_b=0, collision=0, clear counter=0. FSM goes to CLEAR if INIT_CLEAR=1, else to READY. busy=1 in CLEAR. Array contents are not reset directly.
- FSM CLEAR:
  - Writes zeros to B word ctr each cycle, ctr increments.
  - At ctr=2**ADDR_WIDTHB-1, writes the last word and moves to READY next cycle. CLEAR lasts exactly 2**ADDR_WIDTHB cycles.
  - en_a/en_b are ignored in CLEAR: no writes, vld low, dout held at 0.
- FSM READY: normal operation. The only exit is rst; rst asserted mid-CLEAR restarts the clear from 0.
- Read latency 1: an access with en_x=1 in cycle N gives dout_x and vld_x=1 in N+1. With en_x=0, vld_x=0 next cycle and dout_x holds its last value.
- Every enabled access reads, including writes. Read data per WRITE_FIRST:
  - WRITE_FIRST=1: written lanes return new data, unwritten lanes of a B word return stored data.
  - WRITE_FIRST=0: all lanes return pre-write data.
- Cross-port read of a lane written by the other port in the same cycle always returns old data, in both modes.
- Collision: en_a&we_a&en_b&we_b[addr_a[RATIO_LOG2-1:0]] with addr_a[ADDR_WIDTHA-1:RATIO_LOG2]==addr_b.
  - Port B data is stored for that lane; the A write is dropped.
  - collision pulses high in N+1.
  - Port A read data on collision follows the WRITE_FIRST rule with A's own din_a, which is not stored.
- Same B word but different lanes: both writes are stored, no collision.
- Port B with we_b all zero and en_b=1 is a pure read.

Optional Feature:
- Macro SRAMB_ASYM_OREG_EN.
- When defined: an extra output register stage on both ports. Read latency is 2; vld_x and collision are delayed one more cycle; the output registers reset to 0.
- When undefined: latency 1 as above.

Decomposition:
- Package sramb_pkg: derived-width functions (LANES, DATA_WIDTHB, ADDR_WIDTHB), FSM state typedef {CLEAR, READY}, WRITE_FIRST mode constants.
- One natural sub-module: sramb_clear_seq, containing the FSM, address counter, busy, and the clear-write address/data mux. The array and port logic stay in the top.

Test Plan (defaults unless stated):
- Release rst -> busy=1 for exactly 1024 cycles; all B reads after that return 16'h0000; en_a/en_b writes issued during busy leave no trace.
- Write A: addr 14'h0013 = 1 and 14'h0010 = 1 -> B read of addr 10'h001 gives 16'h0009 one cycle after en_b, with vld_b=1.
- B write addr 10'h002, din 16'hFFFF, we_b=16'h00F0 -> A reads of 14'h0024..14'h0027 = 1 and 14'h0020 = 0.
- Same cycle: A writes 0 to 14'h0035 and B writes 16'hFFFF with we_b=16'h0020 to 10'h003 -> collision pulses once; A read of 14'h0035 returns 1.
- WRITE_FIRST=0 vs 1: B word holds 16'h1234, B write 16'hABCD full mask -> dout_b = 16'h1234 vs 16'hABCD.
- Assert rst mid-CLEAR at cycle 500 -> busy stays high for 1024 cycles after release. With SRAMB_ASYM_OREG_EN defined, all the above latencies are +1.
